// File: rtl/arduino_reset_sequencer.sv
// Avalon-MM controlled reset sequencer for the Arduino shield header:
// timed assert pulse, recovery window, sticky DONE with optional interrupt.
module arduino_reset_sequencer #(
   parameter int CNT_W       = 24,
   parameter int DEF_PULSE   = 50000,
   parameter int DEF_RECOVER = 500000,
   parameter int AUTO_POR    = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        rst_out_n,
   output logic        ready,
   output logic        irq
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ASSERT = 2'd1, S_RECOVER = 2'd2} state_t;

   localparam logic [CNT_W-1:0] POR_CNT = (DEF_PULSE > 1) ? CNT_W'(DEF_PULSE - 1) : '0;
   localparam state_t           POR_ST  = (AUTO_POR != 0) ? S_ASSERT : S_IDLE;

   state_t           st, st_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [CNT_W-1:0] pulse, recover;
   logic             frc, frc_nx;
   logic             irq_en, irq_en_nx;
   logic             done, done_nx;
   logic [7:0]       seq_cnt;
   logic             fin;

   logic wr, wr_ctrl, wr_pulse, wr_rec, wr_stat, start, done_clr;

   assign wr        = chipselect & ~write_n;
   assign wr_ctrl   = wr & (address == 2'd0);
   assign wr_pulse  = wr & (address == 2'd1);
   assign wr_rec    = wr & (address == 2'd2);
   assign wr_stat   = wr & (address == 2'd3);
   assign start     = wr_ctrl & writedata[0];
   assign done_clr  = wr_stat & writedata[1];
   assign frc_nx    = wr_ctrl ? writedata[1] : frc;
   assign irq_en_nx = wr_ctrl ? writedata[2] : irq_en;

   generate
      if (CNT_W < 32) begin : g_unused
         logic unused_wd;
         assign unused_wd = ^writedata[31:CNT_W];
      end
   endgenerate

   // Counter holds remaining cycles minus one in the current phase.
   always_comb begin
      st_nx  = st;
      cnt_nx = cnt;
      fin    = 1'b0;
      case (st)
         S_IDLE: begin
            if (start) begin
               st_nx  = S_ASSERT;
               cnt_nx = (pulse == '0) ? '0 : pulse - 1'b1;
            end
         end
         S_ASSERT: begin
            if (cnt == '0) begin
               if (recover != '0) begin
                  st_nx  = S_RECOVER;
                  cnt_nx = recover - 1'b1;
               end else begin
                  st_nx = S_IDLE;
                  fin   = 1'b1;
               end
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         S_RECOVER: begin
            if (cnt == '0) begin
               st_nx = S_IDLE;
               fin   = 1'b1;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: st_nx = S_IDLE;
      endcase
      // a completing sequence beats a same-cycle clear
      done_nx = fin | (done & ~done_clr);
   end

   // Outputs are registered from next-state values so they track state with no bus-to-pin path.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st        <= POR_ST;
         cnt       <= (AUTO_POR != 0) ? POR_CNT : '0;
         pulse     <= CNT_W'(DEF_PULSE);
         recover   <= CNT_W'(DEF_RECOVER);
         frc       <= 1'b0;
         irq_en    <= 1'b0;
         done      <= 1'b0;
         seq_cnt   <= 8'd0;
         rst_out_n <= (AUTO_POR == 0);
         ready     <= 1'b0;
         irq       <= 1'b0;
      end else begin
         st        <= st_nx;
         cnt       <= cnt_nx;
         frc       <= frc_nx;
         irq_en    <= irq_en_nx;
         done      <= done_nx;
         if (fin)      seq_cnt <= seq_cnt + 8'd1;
         if (wr_pulse) pulse   <= writedata[CNT_W-1:0];
         if (wr_rec)   recover <= writedata[CNT_W-1:0];
         rst_out_n <= ~((st_nx == S_ASSERT) | frc_nx);
         ready     <= (st_nx == S_IDLE) & ~frc_nx;
         irq       <= done_nx & irq_en_nx;
      end
   end

   always_comb begin
      readdata = 32'd0;
      case (address)
         2'd0:    readdata = {29'd0, irq_en, frc, 1'b0};
         2'd1:    readdata = 32'(pulse);
         2'd2:    readdata = 32'(recover);
         default: readdata = {16'd0, seq_cnt, 4'd0, st, done, st != S_IDLE};
      endcase
   end

endmodule
